dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// Shares the single-port synchronous D-MEM between two requesters: the CPU MEM stage (port C) and a
// debug/loader port (port D) used to preload or inspect data memory while the core runs.
// Fixed priority to C, with a starvation guard and an optional D lock for multi-word transfers.
// Sits between the MEM stage latch and the dmem array; MMIO addresses bypass the array.
// PARAMETERS
// DBITS        32          data and address width
// DMEMADDRBITS 16          byte-address bits decoded for dmem
// DMEMWORDBITS 2           byte-offset bits dropped to form the word index
// MMIOBASE     32'hFFFFF000 addresses with [31:12]==MMIOBASE[31:12] are MMIO, never reach dmem
// STARVEMAX    8           cycles D may wait before it steals one slot from C
// LOCKMAX      16          maximum consecutive cycles D may hold a lock
// PORTS
// clk         in  1      core clock
// reset       in  1      synchronous, active-high
// c_req       in  1      C access request, valid this cycle
// c_we        in  1      C write (1) / read (0)
// c_addr      in  DBITS  C byte address
// c_wdata     in  DBITS  C write data
// c_stall     out 1      C not granted this cycle; the pipeline holds its MEM stage
// c_rvalid    out 1      C read data valid, one cycle after grant
// c_rdata     out DBITS  C read data
// c_mmio      out 1      C address is MMIO this cycle (combinational, qualified by c_req)
// d_req       in  1      D access request
// d_we        in  1      D write / read
// d_lock      in  1      D requests that ownership be held after this grant
// d_addr      in  DBITS  D byte address
// d_wdata     in  DBITS  D write data
// d_gnt       out 1      D access accepted this cycle
// d_rvalid    out 1      D read data valid, one cycle after grant
// d_rdata     out DBITS  D read data
// mem_en      out 1      dmem access strobe
// mem_we      out 1      dmem write enable
// mem_idx     out DMEMADDRBITS-DMEMWORDBITS  word index = addr[DMEMADDRBITS-1:DMEMWORDBITS]
// mem_wdata   out DBITS  dmem write data
// mem_rdata   in  DBITS  dmem read data, registered in dmem, valid the cycle after mem_en
// BEHAVIOUR
// - Reset values: all outputs 0, state=C_OWN, starve_cnt=0, lock_cnt=0, last_rd_src=none.
// - States:
//   - C_OWN: C wins whenever c_req=1 and the C address is not MMIO.
//     D is granted when C is idle, or when starve_cnt==STARVEMAX; in that case c_stall=1 for that one cycle.
//   - D_OWN: D is granted, and c_stall=1 whenever c_req=1.
// - Transitions:
//   - C_OWN -> D_OWN: D granted with d_lock=1.
//   - D_OWN -> C_OWN: d_lock=0 at grant, or d_req=0, or lock_cnt reaches LOCKMAX-1.
//     On the LOCKMAX-1 cycle D is still granted, then ownership is forcibly released.
// - starve_cnt: increments each cycle d_req=1 && !d_gnt, saturating at STARVEMAX. Clears on d_gnt or d_req=0.
// - lock_cnt: increments each D_OWN cycle and clears on entry to C_OWN.
// - MMIO C access:
//   - c_mmio=1, c_stall=0, mem_en=0, no c_rvalid; the I/O logic owns the data.
//   - C is still considered idle, so D may use dmem in the same cycle.
//   - D MMIO requests are rejected: d_gnt=0, no side effect.
// - Read latency 1: a granted read sets *_rvalid=1 the next cycle, with *_rdata=mem_rdata.
//   The non-selected rdata is 0. Writes never raise rvalid.
// - Writes take effect in dmem at the grant edge. A read of the same index on the next cycle returns the new data.
// - Simultaneous C read + D stolen slot: D accesses; C is stalled and retries next cycle, where it has priority.
// - Reset mid-operation: pending rvalid is dropped, state returns to C_OWN, and the lock is cleared.
// STRUCTURE
// - Shared package holds: MMIOBASE, the state encoding (C_OWN=1'b0, D_OWN=1'b1), and the is_mmio(addr) function.
// - Single module, no sub-modules. The counters and rvalid/source flops are local.
// TESTING
// - Priority: c_req read 0x40, d_req read 0x80, same cycle -> mem_idx=0x10, c_stall=0, d_gnt=0.
//   Next cycle c_rvalid=1, c_rdata=dmem[0x10].
// - Starvation: c_req held 1, d_req held 1 -> d_gnt=1 exactly on the 9th waiting cycle, with c_stall=1 for that cycle only.
// - Lock: D writes 0x200..0x23C with d_lock=1 while c_req=1 -> 16 consecutive d_gnt, c_stall=1 throughout.
//   On the 17th cycle, C_OWN with C granted.
// - MMIO: c_req write 0xFFFFF000 with D write 0x10 -> c_mmio=1, c_stall=0, mem_en=1, mem_idx=0x4 (D access).
// - RAW: D writes 0x55 at 0x8, then C reads 0x8 the next cycle -> c_rdata=0x55.
// - Reset asserted while D_OWN with a read in flight -> next cycle d_rvalid=0, state C_OWN, all outputs 0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared MMIO decode and arbiter state encodings
package dmem_port_arbiter_pkg;

  localparam logic [31:0] MMIOBASE = 32'hFFFFF000;
  localparam logic [31:0] MMIOMASK = 32'hFFFFF000;

  typedef enum logic {
    C_OWN = 1'b0,
    D_OWN = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_C    = 2'd1,
    RD_D    = 2'd2
  } rd_src_e;

  function automatic logic is_mmio(input logic [31:0] addr);
    return (addr & MMIOMASK) == (MMIOBASE & MMIOMASK);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the single-port dmem between the MEM stage (C) and a debug port (D)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int DMEMADDRBITS = 16,
  parameter int DMEMWORDBITS = 2,
  parameter int STARVEMAX    = 8,
  parameter int LOCKMAX      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 c_req,
  input  logic                                 c_we,
  input  logic [DBITS-1:0]                     c_addr,
  input  logic [DBITS-1:0]                     c_wdata,
  output logic                                 c_stall,
  output logic                                 c_rvalid,
  output logic [DBITS-1:0]                     c_rdata,
  output logic                                 c_mmio,
  input  logic                                 d_req,
  input  logic                                 d_we,
  input  logic                                 d_lock,
  input  logic [DBITS-1:0]                     d_addr,
  input  logic [DBITS-1:0]                     d_wdata,
  output logic                                 d_gnt,
  output logic                                 d_rvalid,
  output logic [DBITS-1:0]                     d_rdata,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_idx,
  output logic [DBITS-1:0]                     mem_wdata,
  input  logic [DBITS-1:0]                     mem_rdata
);

  localparam int SCW = $clog2(STARVEMAX + 1);
  localparam int LCW = $clog2(LOCKMAX);
  localparam logic [SCW-1:0] STARVE_SAT = SCW'(STARVEMAX);
  localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCKMAX - 1);

  arb_state_e     state_q, state_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  rd_src_e        rd_src_q, rd_src_d;

  logic c_acc;
  logic d_ok;
  logic steal;
  logic c_gnt;
  logic d_gnt_w;

  always_comb begin
    // Everything hangs off these three terms, so gating them with reset quiets all outputs.
    c_mmio   = !reset && c_req && is_mmio(32'(c_addr));
    c_acc    = !reset && c_req && !c_mmio;
    d_ok     = !reset && d_req && !is_mmio(32'(d_addr));
    steal    = d_ok && (starve_cnt_q == STARVE_SAT);
    c_gnt    = 1'b0;
    d_gnt_w  = 1'b0;
    state_d  = state_q;

    if (state_q == D_OWN) begin
      d_gnt_w = d_ok;
      c_gnt   = c_acc && !d_ok;
      if (!d_req || (d_gnt_w && !d_lock) || (lock_cnt_q == LOCK_LAST)) begin
        state_d = C_OWN;
      end
    end else begin
      c_gnt   = c_acc && !steal;
      d_gnt_w = d_ok && !c_gnt;
      if (d_gnt_w && d_lock) begin
        state_d = D_OWN;
      end
    end

    // The locking grant itself is lock cycle 0, so LOCKMAX bounds the total D grants.
    lock_cnt_d = (state_d == D_OWN) ? lock_cnt_q + 1'b1 : '0;

    if (!d_req || d_gnt_w) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_SAT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    rd_src_d = RD_NONE;
    if (c_gnt && !c_we) begin
      rd_src_d = RD_C;
    end else if (d_gnt_w && !d_we) begin
      rd_src_d = RD_D;
    end

    c_stall   = c_acc && !c_gnt;
    d_gnt     = d_gnt_w;
    mem_en    = c_gnt || d_gnt_w;
    mem_we    = (c_gnt && c_we) || (d_gnt_w && d_we);
    mem_idx   = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_idx   = c_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata = c_wdata;
    end else if (d_gnt_w) begin
      mem_idx   = d_addr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata = d_wdata;
    end

    c_rvalid = !reset && (rd_src_q == RD_C);
    d_rvalid = !reset && (rd_src_q == RD_D);
    c_rdata  = c_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= C_OWN;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
      rd_src_q     <= RD_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_src_q     <= rd_src_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int STARVE  = 8;
  localparam int LOCKLEN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_stall, c_rvalid, c_mmio;
  logic [31:0] c_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] hmem    [0:16383];
  logic [31:0] ref_mem [0:16383];

  int n_pass = 0;
  int n_total = 0;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_mmio(c_mmio),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous dmem with a registered read port.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) hmem[mem_idx] <= mem_wdata;
      else        mem_rdata     <= hmem[mem_idx];
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: who owns dmem, how long D has waited, how long the lock has lasted.
  logic        m_own_d = 1'b0;
  int          m_wait = 0;
  int          m_own_cycles = 0;
  logic        m_pend_c = 1'b0, m_pend_d = 1'b0;
  logic [31:0] m_pend_c_data = '0, m_pend_d_data = '0;
  logic        m_c_win = 1'b0, m_d_win = 1'b0;

  always @(negedge clk) begin
    logic c_io, c_wants, d_wants, steal, e_we;
    c_io    = !reset && c_req && (c_addr[31:12] == 20'hFFFFF);
    c_wants = !reset && c_req && !c_io;
    d_wants = !reset && d_req && (d_addr[31:12] != 20'hFFFFF);
    steal   = d_wants && (m_wait >= STARVE);
    if (m_own_d) begin
      m_d_win = d_wants;
      m_c_win = c_wants && !d_wants;
    end else begin
      m_c_win = c_wants && !steal;
      m_d_win = d_wants && !m_c_win;
    end
    e_we = (m_c_win && c_we) || (m_d_win && d_we);
    chk1("c_stall", c_stall, c_wants && !m_c_win);
    chk1("c_mmio", c_mmio, c_io);
    chk1("d_gnt", d_gnt, m_d_win);
    chk1("mem_en", mem_en, m_c_win || m_d_win);
    chk1("mem_we", mem_we, e_we);
    if (m_c_win) chk32("mem_idx", 32'(mem_idx), 32'(c_addr[15:2]));
    if (m_d_win) chk32("mem_idx", 32'(mem_idx), 32'(d_addr[15:2]));
    if (e_we) chk32("mem_wdata", mem_wdata, m_c_win ? c_wdata : d_wdata);
    chk1("c_rvalid", c_rvalid, !reset && m_pend_c);
    chk32("c_rdata", c_rdata, (!reset && m_pend_c) ? m_pend_c_data : 32'h0);
    chk1("d_rvalid", d_rvalid, !reset && m_pend_d);
    chk32("d_rdata", d_rdata, (!reset && m_pend_d) ? m_pend_d_data : 32'h0);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_own_d = 1'b0; m_wait = 0; m_own_cycles = 0;
      m_pend_c = 1'b0; m_pend_d = 1'b0;
    end else begin
      m_pend_c = m_c_win && !c_we;
      m_pend_d = m_d_win && !d_we;
      m_pend_c_data = ref_mem[c_addr[15:2]];
      m_pend_d_data = ref_mem[d_addr[15:2]];
      if (m_c_win && c_we) ref_mem[c_addr[15:2]] = c_wdata;
      if (m_d_win && d_we) ref_mem[d_addr[15:2]] = d_wdata;
      if (d_req && !m_d_win) m_wait = (m_wait < STARVE) ? m_wait + 1 : STARVE;
      else m_wait = 0;
      if (!m_own_d) begin
        if (m_d_win && d_lock) begin m_own_d = 1'b1; m_own_cycles = 1; end
      end else begin
        m_own_cycles++;
        if (!d_req || (m_d_win && !d_lock) || m_own_cycles >= LOCKLEN) begin
          m_own_d = 1'b0; m_own_cycles = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_gnt, n_stall, n_dgnt, run;
    logic stall_at, stall_ok, done, g;
    for (int i = 0; i < 16384; i++) begin
      hmem[i]    = 32'hA5A5_0000 ^ 32'(i);
      ref_mem[i] = 32'hA5A5_0000 ^ 32'(i);
    end
    idle();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_c_stall", c_stall, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    reset = 1'b0;
    tick();

    // Priority: C wins the same-cycle contest.
    c_req = 1; c_we = 0; c_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    @(negedge clk);
    chk32("prio_idx", 32'(mem_idx), 32'h10);
    chk1("prio_c_stall", c_stall, 1'b0);
    chk1("prio_d_gnt", d_gnt, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk1("prio_c_rvalid", c_rvalid, 1'b1);
    chk32("prio_c_rdata", c_rdata, 32'hA5A5_0010);
    tick();

    // Starvation: D steals one slot on its 9th waiting cycle.
    c_req = 1; c_we = 0; c_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h84;
    first_gnt = 0; n_stall = 0; n_dgnt = 0; stall_at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (d_gnt) begin
        n_dgnt++;
        if (first_gnt == 0) begin first_gnt = n; stall_at = c_stall; end
      end
      if (c_stall) n_stall++;
      tick();
    end
    chk32("starve_first", 32'(first_gnt), 32'd9);
    chk1("starve_stall", stall_at, 1'b1);
    chk32("starve_nstall", 32'(n_stall), 32'd2);
    chk32("starve_ngnt", 32'(n_dgnt), 32'd2);
    idle(); tick();

    // Lock: a stolen locked slot runs for 16 grants, then C gets the array back.
    c_req = 1; c_we = 0; c_addr = 32'h100;
    d_req = 1; d_we = 1; d_lock = 1; d_addr = 32'h200; d_wdata = 32'h1000_0200;
    run = 0; stall_ok = 1; done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      g = d_gnt;
      if (g) begin
        run++;
        if (!c_stall) stall_ok = 0;
      end else if (run > 0) begin
        done = 1;
        chk1("lock_after_stall", c_stall, 1'b0);
        chk1("lock_after_en", mem_en, 1'b1);
        chk32("lock_after_idx", 32'(mem_idx), 32'h40);
      end
      tick();
      if (g) begin d_addr = d_addr + 4; d_wdata = 32'h1000_0000 | d_addr; end
    end
    chk1("lock_done", done, 1'b1);
    chk32("lock_run", 32'(run), 32'd16);
    chk1("lock_stall_all", stall_ok, 1'b1);
    idle(); tick();

    // Read back a word written under the lock.
    d_req = 1; d_we = 0; d_addr = 32'h204;
    tick(); idle();
    @(negedge clk);
    chk32("lock_readback", d_rdata, 32'h1000_0204);
    tick();

    // MMIO: C bypasses dmem, D uses it in the same cycle.
    c_req = 1; c_we = 1; c_addr = 32'hFFFF_F000; c_wdata = 32'h1234_5678;
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_0010;
    @(negedge clk);
    chk1("mmio_c_mmio", c_mmio, 1'b1);
    chk1("mmio_c_stall", c_stall, 1'b0);
    chk1("mmio_mem_en", mem_en, 1'b1);
    chk32("mmio_idx", 32'(mem_idx), 32'h4);
    chk1("mmio_d_gnt", d_gnt, 1'b1);
    tick(); idle();
    d_req = 1; d_we = 1; d_addr = 32'hFFFF_F004;
    @(negedge clk);
    chk1("dmmio_gnt", d_gnt, 1'b0);
    chk1("dmmio_en", mem_en, 1'b0);
    tick(); idle(); tick();

    // Read-after-write across ports.
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'h55;
    tick(); idle();
    c_req = 1; c_we = 0; c_addr = 32'h8;
    tick(); idle();
    @(negedge clk);
    chk1("raw_rvalid", c_rvalid, 1'b1);
    chk32("raw_rdata", c_rdata, 32'h55);
    tick();

    // Reset while D owns the array with a read in flight.
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h80;
    tick();
    d_addr = 32'h84;
    @(negedge clk);
    chk1("rstlk_gnt", d_gnt, 1'b1);
    chk1("rstlk_rvalid", d_rvalid, 1'b1);
    tick();
    idle(); reset = 1;
    @(negedge clk);
    chk1("rstlk_drop", d_rvalid, 1'b0);
    chk1("rstlk_en", mem_en, 1'b0);
    tick();
    reset = 0;
    c_req = 1; c_we = 0; c_addr = 32'h40;
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h84;
    @(negedge clk);
    chk1("rstlk_c_own_dgnt", d_gnt, 1'b0);
    chk1("rstlk_c_own_stall", c_stall, 1'b0);
    chk1("rstlk_d_rvalid", d_rvalid, 1'b0);
    tick(); idle();
    @(negedge clk);
    chk32("rstlk_c_rdata", c_rdata, 32'hA5A5_0010);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
